// File: rtl/aurras_pkg.sv
// rtl/aurras_pkg.sv - shared types and helpers for the IR capture buffer
package aurras_pkg;

    typedef enum logic [1:0] {
        EMPTY       = 2'd0,
        CAPTURING   = 2'd1,
        NORMALIZING = 2'd2,
        READY       = 2'd3
    } ir_buf_state_t;

    localparam logic signed [15:0] IR_MAX_POS = 16'sd32767;

    // Magnitude of a signed sample; full-scale negative saturates to the positive limit.
    function automatic logic [15:0] sat_abs(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == -16'sd32768) begin
            r = IR_MAX_POS;
        end else if (x < 16'sd0) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/ir_sample_ram.sv
// rtl/ir_sample_ram.sv - simple dual-port IR sample memory with registered read
module ir_sample_ram #(
    parameter int DEPTH = 24000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          audio_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge audio_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ir_capture_buffer.sv
// rtl/ir_capture_buffer.sv - stores a captured impulse response and serves normalised taps
module ir_capture_buffer
    import aurras_pkg::*;
#(
    parameter int DEPTH     = 24000,
    parameter int MAX_SHIFT = 8
) (
    input  logic        audio_clk,
    input  logic        rst_in,
    input  logic        ir_data_in_valid,
    input  logic [15:0] ir_sample_index,
    input  logic [15:0] write_data,
    input  logic        impulse_recorded,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        ir_ready,
    output logic [15:0] ir_length,
    output logic [3:0]  norm_shift,
    output logic [15:0] peak_mag,
    output logic        overflow_err
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_W     = 17'(DEPTH);
    localparam logic [3:0]  MAX_SHIFT_W = 4'(MAX_SHIFT);

    ir_buf_state_t state, state_next;
    logic [3:0]  shift_cnt;
    logic        start_capture;
    logic        in_range;
    logic        wr_en;
    logic        norm_continue;
    logic [16:0] new_len;
    logic [15:0] wr_abs;
    logic [15:0] ram_q;
    logic        rd_accept;
    logic        rd_p1_valid;
    logic        rd_p1_oob;

    assign start_capture = ir_data_in_valid && (ir_sample_index == 16'd0)
                           && ((state == EMPTY) || (state == READY));
    assign in_range      = {1'b0, ir_sample_index} < DEPTH_W;
    assign wr_en         = ir_data_in_valid && in_range
                           && (start_capture || (state == CAPTURING));
    assign new_len       = {1'b0, ir_sample_index} + 17'd1;
    assign wr_abs        = sat_abs(write_data);
    // Keep shifting while one more doubling of the peak still fits the positive range.
    assign norm_continue = (shift_cnt < MAX_SHIFT_W)
                           && ((32'(peak_mag) << (shift_cnt + 4'd1)) <= 32'd32767);
    assign rd_accept     = rd_req && ir_ready;

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY, READY: if (start_capture)     state_next = CAPTURING;
            CAPTURING:    if (impulse_recorded)  state_next = NORMALIZING;
            NORMALIZING:  if (!norm_continue)    state_next = READY;
            default:                             state_next = EMPTY;
        endcase
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            ir_ready     <= 1'b0;
            ir_length    <= 16'd0;
            norm_shift   <= 4'd0;
            peak_mag     <= 16'd0;
            overflow_err <= 1'b0;
            shift_cnt    <= 4'd0;
        end else begin
            case (state)
                EMPTY, READY: begin
                    if (start_capture) begin
                        ir_ready     <= 1'b0;
                        overflow_err <= 1'b0;
                        ir_length    <= 16'd1;
                        peak_mag     <= wr_abs;
                        shift_cnt    <= 4'd0;
                    end
                end
                CAPTURING: begin
                    if (ir_data_in_valid) begin
                        if (!in_range) begin
                            overflow_err <= 1'b1;
                        end else if (new_len > {1'b0, ir_length}) begin
                            ir_length <= new_len[15:0];
                        end
                        if (wr_abs > peak_mag) begin
                            peak_mag <= wr_abs;
                        end
                    end
                    if (impulse_recorded) begin
                        shift_cnt <= 4'd0;
                    end
                end
                NORMALIZING: begin
                    if (norm_continue) begin
                        shift_cnt <= shift_cnt + 4'd1;
                    end else begin
                        norm_shift <= shift_cnt;
                        ir_ready   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ir_sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .audio_clk (audio_clk),
        .wr_en     (wr_en),
        .wr_addr   (ir_sample_index[AW-1:0]),
        .wr_data   (write_data),
        .rd_addr   (rd_addr[AW-1:0]),
        .rd_data   (ram_q)
    );

    // Out-of-range taps are flagged at accept time and forced to zero at the output stage.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            rd_p1_valid <= 1'b0;
            rd_p1_oob   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= 16'd0;
        end else begin
            rd_p1_valid <= rd_accept;
            rd_p1_oob   <= rd_addr >= ir_length;
            rd_valid    <= rd_p1_valid;
            if (rd_p1_valid) begin
                rd_data <= rd_p1_oob ? 16'd0 : 16'($signed(ram_q) <<< norm_shift);
            end
        end
    end

endmodule

// File: doc/ir_capture_buffer.md
Name: ir_capture_buffer

Overview:
Sits directly downstream of the impulse-recording stage. Consumes its per-sample write stream (index, data, valid) and end-of-capture pulse, and stores the impulse response in on-chip memory. On completion it computes a power-of-two normalisation gain from the peak magnitude. It then serves normalised IR taps through a fixed-latency random-read port to the downstream convolution engine.

Parameters:
DEPTH, 24000, IR memory depth in samples; indices >= DEPTH are not stored.
MAX_SHIFT, 8, largest normalisation left-shift applied.

Ports:
audio_clk  input  1  single system clock.
rst_in  input  1  synchronous, active-high reset.
ir_data_in_valid  input  1  one-cycle strobe: store write_data at ir_sample_index.
ir_sample_index  input  16  write address of the current sample.
write_data  input  16  signed IR sample.
impulse_recorded  input  1  one-cycle strobe: capture finished.
rd_req  input  1  read request, accepted only when ir_ready=1.
rd_addr  input  16  tap index to read.
rd_valid  output  1  rd_data valid, exactly 2 cycles after an accepted rd_req.
rd_data  output  16  signed normalised tap.
ir_ready  output  1  a complete, normalised IR is held.
ir_length  output  16  stored samples (highest stored index + 1).
norm_shift  output  4  applied left-shift, 0..MAX_SHIFT.
peak_mag  output  16  peak absolute sample value of the last capture.
overflow_err  output  1  sticky; an index >= DEPTH arrived during the current capture.

Behaviour:
- Reset: state EMPTY; all outputs 0, including rd_valid, rd_data, ir_ready, ir_length, norm_shift, peak_mag and overflow_err. Memory contents are don't-care.
- States: EMPTY, CAPTURING, NORMALIZING, READY.
- EMPTY/READY -> CAPTURING: on ir_data_in_valid with ir_sample_index==0.
  - That sample is written.
  - ir_ready, peak_mag and overflow_err are cleared on the next cycle.
  - ir_length is set to 1.
- In EMPTY/READY, valid strobes with a nonzero index are ignored, as is impulse_recorded.
- CAPTURING, per valid strobe:
  - Index < DEPTH: write memory; ir_length <= max(ir_length, index+1).
  - Index >= DEPTH: write dropped; overflow_err <= 1.
  - All strobes: peak_mag <= max(peak_mag, |data|), with |-32768| saturated to 32767.
- CAPTURING -> NORMALIZING: on impulse_recorded. If impulse_recorded and ir_data_in_valid coincide, the sample is processed first, then the transition is taken.
- NORMALIZING, iterative, one step per cycle:
  - Starts with s=0.
  - While s < MAX_SHIFT and (peak_mag << (s+1)) <= 32767: s <= s+1.
  - On stop: norm_shift <= s, then -> READY with ir_ready=1 on the following cycle.
  - peak_mag==0 yields MAX_SHIFT.
  - Worst case takes MAX_SHIFT+1 cycles.
  - Strobes arriving in NORMALIZING are ignored.
- READY read path, 2-cycle pipeline:
  - Cycle 0: rd_req && ir_ready accepted.
  - Cycle 1: memory output registered.
  - Cycle 2: rd_valid=1, rd_data = mem[rd_addr] <<< norm_shift. This never overflows by construction.
  - rd_addr >= ir_length: rd_valid=1, rd_data=0.
  - Back-to-back requests are allowed, one per cycle, full throughput.
- rd_req when ir_ready=0 is dropped, with no rd_valid.
- A read in flight when a new capture starts still completes, with undefined data.
- rd_valid is low whenever no accepted request is 2 cycles old; rd_data holds its last value.
- Reset mid-capture or mid-read: returns to EMPTY immediately, and pending rd_valid is squashed.

Decomposition:
- Shared package (aurras_pkg): ir_buf_state_t enum (EMPTY=0, CAPTURING=1, NORMALIZING=2, READY=3) and constant IR_MAX_POS = 16'sd32767.
- One sub-module: ir_sample_ram. Simple dual-port, one write and one read port, registered read, DEPTH x 16, BRAM-inferable.

Test Plan:
- Basic capture: write indices 0..9 with data 100*i, then impulse_recorded.
  - Expect peak_mag=900, norm_shift=5 (900<<5=28800 and 900<<6>32767) and ir_length=10.
  - ir_ready rises within 10 cycles.
  - Read addr 3 -> rd_data 9600 after exactly 2 cycles.
- Negative full-scale: capture includes -32768.
  - Expect peak_mag=32767, norm_shift=0; read returns -32768 unchanged.
- All-zero IR of length 4.
  - Expect norm_shift=8, peak_mag=0; reads return 0, and addr 4 -> 0 with rd_valid.
- Overflow: DEPTH=16, indices 0..19.
  - Expect ir_length=16, overflow_err=1; it clears when a new index-0 strobe starts the next capture.
- Read handshake:
  - rd_req while CAPTURING -> no rd_valid.
  - In READY, 5 consecutive rd_req -> 5 consecutive rd_valid cycles starting 2 cycles later, in address order.
- Reset: rst_in asserted in NORMALIZING and with a read in flight.
  - Next cycle all outputs are 0 and state is EMPTY.
  - A subsequent impulse_recorded without an index-0 start is ignored.
